// File: rtl/cc_pkg.sv
// cc_pkg: shared state encoding, NZP codes and word classification for cc_sched.
package cc_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, EVAL} cc_state_t;
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;
  localparam int CC_MAX_W = 64;
  // word is zero-extended to CC_MAX_W; w is the real width so the sign bit is word[w-1]
  function automatic logic [2:0] cc_classify(input logic [CC_MAX_W-1:0] word, input int w);
    return word == '0 ? CC_Z : word[6'(w - 1)] ? CC_N : CC_P;
  endfunction
endpackage

// File: rtl/cc_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts at ptr, ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int NUM_SRC = 2,
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] gnt,
  output logic [PW-1:0]      win
);
  logic [PW-1:0] ptr;
  function automatic int slot(input int i);
    return (int'(ptr) + i) % NUM_SRC;
  endfunction
  // scan farthest-first so the requester closest to ptr overwrites the rest
  always_comb begin
    gnt = '0;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[slot(i)]) begin
        gnt = NUM_SRC'(1) << slot(i);
        win = PW'(slot(i));
      end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) ptr <= '0;
    else if (advance) ptr <= PW'((int'(win) + 1) % NUM_SRC);
endmodule

// File: rtl/cc_sched.sv
// cc_sched: LC-3 NZP condition-code scheduler; arbitrates CC writes and sequences branch evaluation.
// Optional CC_STALL_CNT_EN adds stall_cnt, counting cycles a branch waits for service.
module cc_sched
  import cc_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 16
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      br_req,
  input  logic [2:0]                br_cond,
  output logic                      br_ack,
  output logic                      br_taken,
  output logic [2:0]                cc_out,
  output logic                      cc_busy
`ifdef CC_STALL_CNT_EN
  ,output logic [15:0]              stall_cnt
`endif
);
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  cc_state_t state, state_nx;
  logic [NUM_SRC-1:0] gnt;
  logic [PW-1:0] win;
  logic [DATA_W-1:0] word;
  logic br_prio, br_first;
  assign br_first = br_prio && br_req;
  assign src_ready = (Reset_n && state == IDLE && !br_first) ? gnt : '0;
  assign cc_busy = state != IDLE || |src_valid;
  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .Clk(Clk), .Reset_n(Reset_n), .req(src_valid), .advance(|src_ready), .gnt(gnt), .win(win)
  );
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  // a branch that waited out one write jumps ahead of further writes
  always_comb
    state_nx = state != IDLE ? IDLE :
               br_first      ? EVAL :
               |src_valid    ? WRITE :
               br_req        ? EVAL : IDLE;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      word     <= '0;
      cc_out   <= '0;
      br_ack   <= 1'b0;
      br_taken <= 1'b0;
      br_prio  <= 1'b0;
    end else begin
      br_ack <= state == EVAL;
      if (|src_ready) word <= src_data[int'(win)*DATA_W +: DATA_W];
      if (state == WRITE) begin
        cc_out  <= cc_classify(CC_MAX_W'(word), DATA_W);
        br_prio <= br_req;
      end
      if (state == EVAL) begin
        br_taken <= |(br_cond & cc_out);
        br_prio  <= 1'b0;
      end
    end
`ifdef CC_STALL_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) stall_cnt <= '0;
    else if (br_req && state != EVAL && !br_ack && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_cc_sched.sv
// tb_cc_sched: directed and random checks of cc_sched against a transaction-level reference model.
module tb_cc_sched;
  localparam int N = 2, W = 16;
  logic Clk = 1'b0, Reset_n = 1'b1;
  logic [N-1:0] src_valid = '0;
  logic [N*W-1:0] src_data = '0;
  logic br_req = 1'b0;
  logic [2:0] br_cond = '0;
  logic [N-1:0] src_ready;
  logic br_ack, br_taken, cc_busy;
  logic [2:0] cc_out;
`ifdef CC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  cc_sched #(.NUM_SRC(N), .DATA_W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .br_req(br_req), .br_cond(br_cond), .br_ack(br_ack), .br_taken(br_taken), .cc_out(cc_out),
    .cc_busy(cc_busy)
`ifdef CC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 Clk = ~Clk;
  int total = 0, bad = 0;
  logic [2:0] m_cc, m_taken;
  logic m_ack, m_prio;
  int m_ptr, m_ph;
  logic [15:0] m_word, m_stall;
  logic [1:0] gr;
  logic seen, bra;
  logic [2:0] cnd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] cls(input logic [15:0] w);
    return w == 0 ? 3'b010 : w[15] ? 3'b100 : 3'b001;
  endfunction
  function automatic logic [15:0] rnd();
    int k = $urandom_range(3);
    return k == 0 ? 16'h0 : k == 1 ? (16'h8000 | 16'($urandom)) : (16'h7FFF & 16'($urandom));
  endfunction
  task automatic model_reset();
    m_cc = 0; m_taken = 0; m_ack = 0; m_prio = 0; m_ptr = 0; m_ph = 0; m_word = 0; m_stall = 0;
  endtask
  task automatic rst(input logic [1:0] v);
    src_valid = v;
    br_req = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_cc", cc_out, 0);
    chk("rst_ack", br_ack, 0);
    chk("rst_taken", br_taken, 0);
    chk("rst_ready", src_ready, 0);
`ifdef CC_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    src_valid = '0;
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
  endtask
  // m_ph: 0 nothing pending, 1 a write is pending, 2 a branch evaluation is pending
  task automatic cyc(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                     input logic br, input logic [2:0] cond, output logic [1:0] seen_gnt);
    int w;
    logic [1:0] g;
    src_valid = v; src_data = {d1, d0}; br_req = br; br_cond = cond;
    #1;
    g = '0; w = -1;
    if (m_ph == 0 && !(m_prio && br) && v != 0) begin
      w = v[m_ptr] ? m_ptr : 1 - m_ptr;
      g[w] = 1'b1;
    end
    seen_gnt = src_ready;
    chk("ready", src_ready, g);
    chk("busy", cc_busy, m_ph != 0 || v != 0);
    @(posedge Clk);
    if (br && m_ph != 2 && !m_ack && m_stall != 16'hFFFF) m_stall++;
    m_ack = m_ph == 2;
    if (m_ph == 1) begin
      m_cc = cls(m_word); m_prio = br; m_ph = 0;
    end else if (m_ph == 2) begin
      m_taken = |(cond & m_cc); m_prio = 0; m_ph = 0;
    end else if (m_prio && br) m_ph = 2;
    else if (w >= 0) begin
      m_word = w == 1 ? d1 : d0; m_ptr = 1 - w; m_ph = 1;
    end else if (br) m_ph = 2;
    #1;
    chk("cc", cc_out, m_cc);
    chk("ack", br_ack, m_ack);
    chk("taken", br_taken, m_taken);
`ifdef CC_STALL_CNT_EN
    chk("stall", stall_cnt, m_stall);
`endif
  endtask
  initial begin
    model_reset();
    rst(2'b11);
    begin
      logic [15:0] words [3] = '{16'h0000, 16'h8001, 16'h7FFF};
      logic [2:0] exps [3] = '{3'b010, 3'b100, 3'b001};
      for (int i = 0; i < 3; i++) begin
        cyc(2'b01, words[i], 16'h0, 1'b0, 3'b0, gr);
        cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
        chk("classify", cc_out, exps[i]);
      end
    end
    rst(2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11, rnd(), rnd(), 1'b0, 3'b0, gr);
      chk("rr", gr, i % 2 ? 2'b00 : (i % 4 == 0 ? 2'b01 : 2'b10));
      chk("onehot", $countones(gr) <= 1, 1);
    end
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
    for (int k = 0; k < 2; k++) begin
      cnd = k == 0 ? 3'b100 : 3'b011;
      cyc(2'b10, 16'h0, 16'hFFFF, 1'b1, cnd, gr);
      chk("ord_grant", gr, 2'b10);
      cyc(2'b00, 16'h0, 16'h0, 1'b1, cnd, gr);
      chk("ord_cc", cc_out, 3'b100);
      cyc(2'b00, 16'h0, 16'h0, 1'b1, cnd, gr);
      cyc(2'b00, 16'h0, 16'h0, 1'b1, cnd, gr);
      chk("ord_ack", br_ack, 1);
      chk("ord_taken", br_taken, k == 0);
      cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cyc(2'b11, rnd(), rnd(), 1'b1, 3'b001, gr);
      seen = br_ack;
    end
    chk("starve", seen, 1);
    cyc(2'b11, rnd(), rnd(), 1'b0, 3'b0, gr);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
    rst(2'b00);
    cyc(2'b01, 16'h0000, 16'h0, 1'b0, 3'b0, gr);
    rst(2'b00);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 3'b0, gr);
    chk("rst_write", cc_out, 3'b000);
    bra = 1'b0; cnd = '0;
    repeat (400) begin
      if (!bra && $urandom_range(3) == 0) begin
        bra = 1'b1; cnd = 3'($urandom);
      end
      cyc(2'($urandom), rnd(), rnd(), bra, cnd, gr);
      if (br_ack && $urandom_range(2) != 0) bra = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
